ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 50 +++++
 rtl/ps2_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM states,
// scan-code classification and the FIFO entry layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    CODE_MAKE,
    CODE_EXT,
    CODE_BREAK
  } code_kind_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;
  localparam int         DATA_BITS  = FRAME_BITS - 3;
  localparam int         ENTRY_W    = 9;

  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } entry_t;

  // E0 is an extended-code prefix and travels through the FIFO like any make code.
  function automatic code_kind_t classify(input logic [7:0] code);
    if (code == BREAK_CODE) return CODE_BREAK;
    if (code == EXT_CODE) return CODE_EXT;
    return CODE_MAKE;
  endfunction

  function automatic logic parity_ok(input logic [7:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rd_data;
// a write into a full FIFO only succeeds when a read frees a slot that cycle.
module sync_fifo #(
  parameter int DW = 9,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_fire;
  logic          wr_fire;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the pins, decodes 11-bit frames with
// parity/stop checking and timeout, folds F0 break prefixes, and queues codes.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int BREAK_FOLD  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_en,
  output logic [ENTRY_W-1:0]   rd_data,
  output logic                 rd_valid,
  output logic [FIFO_AW:0]     count,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 clr_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_last;
  logic                   fall;
  logic                   bit_in;

  rx_state_t              state;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          tcnt;
  logic                   break_pending;
  logic                   push_valid;
  entry_t                 push_entry;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;

  // Preset to idle-high so leaving reset never looks like a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_last  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_last & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bitcnt        <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      tcnt          <= '0;
      break_pending <= 1'b0;
      push_valid    <= 1'b0;
      push_entry    <= '0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      push_valid <= 1'b0;

      if (fall) tcnt <= '0;
      else if (state != ST_IDLE) tcnt <= tcnt + 1'b1;

      // A stalled frame is abandoned, and any half-seen break sequence with it.
      if (!fall && state != ST_IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
        frame_err     <= 1'b1;
        state         <= ST_IDLE;
        break_pending <= 1'b0;
        tcnt          <= '0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'(DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= bit_in;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!parity_ok(shreg, par_bit)) begin
              parity_err <= 1'b1;
            end else if (!bit_in) begin
              frame_err <= 1'b1;
            end else if (BREAK_FOLD != 0 && classify(shreg) == CODE_BREAK) begin
              break_pending <= 1'b1;
            end else begin
              push_valid      <= 1'b1;
              push_entry.brk  <= (BREAK_FOLD != 0) && break_pending;
              push_entry.code <= shreg;
              break_pending   <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign pop      = rd_en & ~fifo_empty;
  assign rd_valid = ~fifo_empty;

  // A fresh drop outranks a same-cycle clear so no lost byte goes unreported.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (push_valid && fifo_full && !pop) overflow <= 1'b1;
    else if (clr_err) overflow <= 1'b0;
  end

  sync_fifo #(
    .DW (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_valid),
    .wr_data (push_entry),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomised frames against a queue-based model of the receiver:
// expected entries, overflow state and error pulse totals come from the model.
module tb_ps2_rx_fifo;

  localparam int FIFO_AW     = 3;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 100;
  localparam int BREAK_FOLD  = 1;
  localparam int DEPTH       = 1 << FIFO_AW;
  localparam int HALF        = 6;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;
  logic rd_en;
  logic clr_err;
  logic [8:0] rd_data;
  logic rd_valid;
  logic [FIFO_AW:0] count;
  logic parity_err;
  logic frame_err;
  logic overflow;

  int test_count = 0;
  int fail_count = 0;
  int perr_seen  = 0;
  int ferr_seen  = 0;
  int exp_perr   = 0;
  int exp_ferr   = 0;
  logic [8:0] exp_q[$];
  logic exp_bp  = 1'b0;
  logic exp_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_AW     (FIFO_AW),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BREAK_FOLD  (BREAK_FOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  // Pulse totals: a pulse stuck high for extra cycles shows up as an excess count.
  always @(negedge clk) begin
    if (parity_err) perr_seen++;
    if (frame_err) ferr_seen++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] code, input logic bad_par,
                             input logic stop, input logic pop, input logic clr);
    if (pop && exp_q.size() > 0) exp_q.delete(0);
    if (clr) exp_ovf = 1'b0;
    if (bad_par) exp_perr++;
    else if (!stop) exp_ferr++;
    else if (BREAK_FOLD != 0 && code == 8'hF0) exp_bp = 1'b1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({exp_bp, code});
      else exp_ovf = 1'b1;
      exp_bp = 1'b0;
    end
  endtask

  // One full frame; rd_en/clr_err are held for exactly the push cycle when requested.
  task automatic applyStimulus(input logic [7:0] code, input logic bad_par,
                               input logic stop, input logic pop, input logic clr);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    ps2_data = stop;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(SYNC_STAGES + 1);
    if (pop && exp_q.size() > 0) checkOutput("head_before_pop", 32'(rd_data), 32'(exp_q[0]));
    rd_en   = pop;
    clr_err = clr;
    wait_clk(1);
    rd_en   = 1'b0;
    clr_err = 1'b0;
    wait_clk(HALF - SYNC_STAGES - 2);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(HALF);
    model_frame(code, bad_par, stop, pop, clr);
  endtask

  task automatic checkModel();
    checkOutput("count", 32'(count), 32'(exp_q.size()));
    checkOutput("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("parity_err_pulses", 32'(perr_seen), 32'(exp_perr));
    checkOutput("frame_err_pulses", 32'(ferr_seen), 32'(exp_ferr));
    if (exp_q.size() != 0) checkOutput("rd_data_head", 32'(rd_data), 32'(exp_q[0]));
  endtask

  task automatic readOne();
    if (exp_q.size() != 0) begin
      checkOutput("rd_data", 32'(rd_data), 32'(exp_q[0]));
      exp_q.delete(0);
    end
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    wait_clk(1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_parity_err", 32'(parity_err), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    int found;
    int r;
    logic [7:0] code;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    wait_clk(3);
    checkResetOutputs();
    rst = 1'b0;
    wait_clk(2);

    // Make, break prefix, make: the second 0x79 carries the break flag.
    applyStimulus(8'h79, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h79, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel();
    readOne();
    readOne();
    checkModel();

    // Wrong parity bit on 0x7A is rejected, then the correct frame is accepted.
    applyStimulus(8'h7A, 1'b1, 1'b1, 1'b0, 1'b0);
    checkModel();
    applyStimulus(8'h7A, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel();
    readOne();

    // Nine bytes into an eight-deep FIFO; then a drop coinciding with clr_err.
    for (int c = 8'h69; c <= 8'h71; c++) applyStimulus(8'(c), 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel();
    applyStimulus(8'h72, 1'b0, 1'b1, 1'b0, 1'b1);
    checkModel();
    for (int i = 0; i < DEPTH; i++) readOne();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    exp_ovf = 1'b0;
    wait_clk(1);
    checkModel();

    // Full FIFO with a pop in the push cycle: no overflow, head advances.
    for (int c = 8'h69; c <= 8'h70; c++) applyStimulus(8'(c), 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h71, 1'b0, 1'b1, 1'b1, 1'b0);
    checkModel();
    for (int i = 0; i < DEPTH; i++) readOne();
    checkModel();

    // Start bit plus four data bits, then silence until the timeout fires.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    found = -1;
    for (int k = 1; k <= TIMEOUT_CYC + 20; k++) begin
      wait_clk(1);
      if (k == HALF) ps2_clk = 1'b1;
      if (frame_err && found < 0) found = k;
    end
    checkOutput("timeout_latency", 32'(found), 32'(TIMEOUT_CYC + SYNC_STAGES + 1));
    exp_ferr++;
    applyStimulus(8'h6B, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel();

    // Reset in the middle of a frame drops it silently and clears the FIFO.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    wait_clk(1);
    checkResetOutputs();
    rst = 1'b0;
    exp_q.delete();
    exp_bp  = 1'b0;
    exp_ovf = 1'b0;
    wait_clk(TIMEOUT_CYC + 10);
    checkModel();
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel();
    applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel();
    readOne();

    // Randomised traffic: break prefixes, E0, corrupted frames, reads and clears.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) code = 8'hF0;
      else if (r == 2) code = 8'hE0;
      else code = 8'($urandom_range(0, 255));
      applyStimulus(code, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      r = $urandom_range(0, 2);
      for (int i = 0; i < r; i++) if ($urandom_range(0, 1) == 1) readOne();
      checkModel();
    end
    while (exp_q.size() != 0) readOne();
    readOne();
    checkModel();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
